// File: rtl/register_access_master_pkg.sv
// Shared types and constants for the UART register-access initiator.
// Holds the UART byte-stream packet, the register command record and the
// initiator FSM state encoding.
package register_access_master_pkg;

    // One byte of a UART_Packets stream with its framing fields.
    typedef struct packed {
        logic [7:0] Source;
        logic [7:0] Destination;
        logic [7:0] Length;
        logic [7:0] Data;
        logic       SoP;
        logic       EoP;
        logic       Valid;
    } UART_PACKET;

    localparam logic [7:0] CMD_WRITE      = 8'h01;
    localparam logic [7:0] CMD_READ       = 8'h00;
    localparam logic [7:0] REG_RSP_LENGTH = 8'd5;
    localparam logic [7:0] REG_WR_LENGTH  = 8'd5;
    localparam logic [7:0] REG_RD_LENGTH  = 8'd1;

    // A single register access captured from the command source.
    typedef struct packed {
        logic        Write;
        logic [7:0]  Address;
        logic [31:0] Data;
    } REG_CMD;

    typedef enum logic [1:0] {
        StIdle,
        StSend,
        StWaitRsp,
        StRecv
    } regAccessState;

    // Request payload byte at a given packet position: address first, then data LSB first.
    function automatic logic [7:0] reqByte(input REG_CMD cmd, input logic [2:0] index);
        logic [7:0] result;
        case (index)
            3'd1:    result = cmd.Data[7:0];
            3'd2:    result = cmd.Data[15:8];
            3'd3:    result = cmd.Data[23:16];
            3'd4:    result = cmd.Data[31:24];
            default: result = cmd.Address;
        endcase
        return result;
    endfunction

endpackage

// File: rtl/register_access_master_register_response_parser.sv
// register_response_parser: checks the body of a read-response packet and
// assembles the 32-bit read data. Byte 0 is the echoed address, bytes 1-4
// carry data LSB first, and EoP must land exactly on byte 4.
module register_response_parser #(
    parameter int unsigned BLOCK_WIDTH = 32
) (
    input  logic                   ipClk,
    input  logic                   ipReset,
    input  logic                   ipStart,
    input  logic                   ipActive,
    input  logic                   ipValid,
    input  logic                   ipSoP,
    input  logic                   ipEoP,
    input  logic [7:0]             ipByte,
    input  logic [7:0]             ipAddress,
    output logic [BLOCK_WIDTH-1:0] opData,
    output logic                   opDone,
    output logic                   opFail
);

    logic [2:0]  idxQ, idxD;
    logic [23:0] asmQ, asmD;
    logic        headerByte;
    logic        bodyByte;

    // A new SoP while parsing restarts at byte 0, same as the opening header.
    assign headerByte = ipStart || (ipActive && ipValid && ipSoP);
    assign bodyByte   = ipActive && ipValid && !ipSoP;

    // The final data byte is taken straight from the stream so the result is ready with EoP.
    assign opData = {ipByte, asmQ};

    // Byte checking and data assembly.
    always_comb begin
        idxD   = idxQ;
        asmD   = asmQ;
        opDone = 1'b0;
        opFail = 1'b0;
        if (headerByte) begin
            idxD = 3'd1;
            if (ipByte != ipAddress || ipEoP) begin
                opFail = 1'b1;
            end
        end else if (bodyByte) begin
            idxD = idxQ + 3'd1;
            case (idxQ)
                3'd1:    asmD[7:0]   = ipByte;
                3'd2:    asmD[15:8]  = ipByte;
                3'd3:    asmD[23:16] = ipByte;
                default: ;
            endcase
            if (idxQ == 3'd4) begin
                if (ipEoP) begin
                    opDone = 1'b1;
                end else begin
                    opFail = 1'b1;
                end
            end else if (ipEoP) begin
                opFail = 1'b1;
            end
        end
    end

    // Parse position and partial data registers.
    always_ff @(posedge ipClk or negedge ipReset) begin
        if (!ipReset) begin
            idxQ <= 3'd0;
            asmQ <= 24'd0;
        end else begin
            idxQ <= idxD;
            asmQ <= asmD;
        end
    end

endmodule

// File: rtl/register_access_master.sv
// register_access_master: host-side initiator for the UART register-access
// protocol. Serialises single read/write commands into UART_PACKET requests
// and, for reads, parses the returning response packet.
// Optional build macro TIMEOUT_EN adds a read-response timeout of
// TIMEOUT_CYCLES cycles; without it the block waits indefinitely.
module register_access_master
    import register_access_master_pkg::*;
#(
    parameter int unsigned BLOCK_WIDTH    = 32,
    parameter logic [7:0]  LOCAL_ADDR     = 8'h00,
    parameter int unsigned TIMEOUT_CYCLES = 50_000_000
) (
    input  logic                   ipClk,
    input  logic                   ipReset,
    input  logic                   ipCmdValid,
    output logic                   opCmdReady,
    input  logic                   ipCmdWrite,
    input  logic [7:0]             ipCmdAddress,
    input  logic [BLOCK_WIDTH-1:0] ipCmdData,
    output UART_PACKET             opTxStream,
    input  logic                   ipTxReady,
    input  UART_PACKET             ipRxStream,
    output logic [BLOCK_WIDTH-1:0] opRdData,
    output logic                   opRdValid,
    output logic                   opWrDone,
    output logic                   opError,
    output logic                   opBusy
);

    if (BLOCK_WIDTH != 32) begin : gBadWidth
        $error("BLOCK_WIDTH must be 32");
    end
    if (TIMEOUT_CYCLES < 2) begin : gBadTimeout
        $error("TIMEOUT_CYCLES must be at least 2");
    end

    regAccessState          stateQ, stateD;
    REG_CMD                 cmdQ, cmdD;
    logic [2:0]             txIdxQ, txIdxD;
    logic [2:0]             lastIdx;
    logic [BLOCK_WIDTH-1:0] rdDataQ, rdDataD;
    logic                   rdValidQ, rdValidD;
    logic                   wrDoneQ, wrDoneD;
    logic                   errorQ, errorD;
    logic                   waiting;
    logic                   rxHeader;
    logic                   parserStart;
    logic [BLOCK_WIDTH-1:0] parserData;
    logic                   parserDone;
    logic                   parserFail;
    logic                   timeout;
    logic                   unusedRx;

    assign unusedRx    = ^ipRxStream.Source;
    assign waiting     = (stateQ == StWaitRsp) || (stateQ == StRecv);
    assign lastIdx     = cmdQ.Write ? 3'd4 : 3'd0;
    assign rxHeader    = ipRxStream.Valid && ipRxStream.SoP &&
                         (ipRxStream.Destination == CMD_READ) &&
                         (ipRxStream.Length == REG_RSP_LENGTH);
    assign parserStart = (stateQ == StWaitRsp) && rxHeader;

    assign opCmdReady = (stateQ == StIdle);
    assign opBusy     = (stateQ != StIdle);
    assign opRdData   = rdDataQ;
    assign opRdValid  = rdValidQ;
    assign opWrDone   = wrDoneQ;
    assign opError    = errorQ;

    register_response_parser #(
        .BLOCK_WIDTH (BLOCK_WIDTH)
    ) uParser (
        .ipClk     (ipClk),
        .ipReset   (ipReset),
        .ipStart   (parserStart),
        .ipActive  (stateQ == StRecv),
        .ipValid   (ipRxStream.Valid),
        .ipSoP     (ipRxStream.SoP),
        .ipEoP     (ipRxStream.EoP),
        .ipByte    (ipRxStream.Data),
        .ipAddress (cmdQ.Address),
        .opData    (parserData),
        .opDone    (parserDone),
        .opFail    (parserFail)
    );

`ifdef TIMEOUT_EN
    localparam int unsigned TimeoutWidth = $clog2(TIMEOUT_CYCLES);
    localparam logic [TimeoutWidth-1:0] TimeoutLast = TimeoutWidth'(TIMEOUT_CYCLES - 1);

    logic [TimeoutWidth-1:0] timeoutCountQ;

    // Response timer: zero outside a pending read, so it restarts on each WAIT_RSP entry.
    always_ff @(posedge ipClk or negedge ipReset) begin
        if (!ipReset) begin
            timeoutCountQ <= '0;
        end else if (waiting) begin
            timeoutCountQ <= timeoutCountQ + 1'b1;
        end else begin
            timeoutCountQ <= '0;
        end
    end

    assign timeout = waiting && (timeoutCountQ == TimeoutLast);
`else
    assign timeout = 1'b0;
`endif

    // Request serialiser: fields are driven only while a byte is on offer.
    always_comb begin
        opTxStream = '0;
        if (stateQ == StSend) begin
            opTxStream.Source      = LOCAL_ADDR;
            opTxStream.Destination = cmdQ.Write ? CMD_WRITE : CMD_READ;
            opTxStream.Length      = cmdQ.Write ? REG_WR_LENGTH : REG_RD_LENGTH;
            opTxStream.Data        = reqByte(cmdQ, txIdxQ);
            opTxStream.SoP         = (txIdxQ == 3'd0);
            opTxStream.EoP         = (txIdxQ == lastIdx);
            opTxStream.Valid       = 1'b1;
        end
    end

    // FSM next state, command capture and result pulses.
    always_comb begin
        stateD   = stateQ;
        cmdD     = cmdQ;
        txIdxD   = txIdxQ;
        rdDataD  = rdDataQ;
        rdValidD = 1'b0;
        wrDoneD  = 1'b0;
        errorD   = 1'b0;
        unique case (stateQ)
            StIdle: begin
                if (ipCmdValid) begin
                    cmdD   = '{Write: ipCmdWrite, Address: ipCmdAddress, Data: ipCmdData};
                    txIdxD = 3'd0;
                    stateD = StSend;
                end
            end
            StSend: begin
                if (ipTxReady) begin
                    if (txIdxQ == lastIdx) begin
                        if (cmdQ.Write) begin
                            wrDoneD = 1'b1;
                            stateD  = StIdle;
                        end else begin
                            stateD = StWaitRsp;
                        end
                    end else begin
                        txIdxD = txIdxQ + 3'd1;
                    end
                end
            end
            StWaitRsp: begin
                if (parserStart) begin
                    stateD = StRecv;
                end
            end
            StRecv: ;
            default: stateD = StIdle;
        endcase

        // Parser outcome takes priority over a coincident timeout.
        if (waiting) begin
            if (parserDone) begin
                rdValidD = 1'b1;
                rdDataD  = parserData;
                stateD   = StIdle;
            end else if (parserFail || timeout) begin
                errorD = 1'b1;
                stateD = StIdle;
            end
        end
    end

    // State and output registers.
    always_ff @(posedge ipClk or negedge ipReset) begin
        if (!ipReset) begin
            stateQ   <= StIdle;
            cmdQ     <= '0;
            txIdxQ   <= 3'd0;
            rdDataQ  <= '0;
            rdValidQ <= 1'b0;
            wrDoneQ  <= 1'b0;
            errorQ   <= 1'b0;
        end else begin
            stateQ   <= stateD;
            cmdQ     <= cmdD;
            txIdxQ   <= txIdxD;
            rdDataQ  <= rdDataD;
            rdValidQ <= rdValidD;
            wrDoneQ  <= wrDoneD;
            errorQ   <= errorD;
        end
    end

endmodule

// File: tb/tb_register_access_master.sv
// Directed self-checking bench for register_access_master.
// Timeout checks follow the TIMEOUT_EN macro used for the build.
module tb_register_access_master;
    import register_access_master_pkg::*;

    localparam logic [7:0] LocalAddr = 8'h5A;

    logic        ipClk;
    logic        ipReset;
    logic        ipCmdValid;
    logic        opCmdReady;
    logic        ipCmdWrite;
    logic [7:0]  ipCmdAddress;
    logic [31:0] ipCmdData;
    UART_PACKET  opTxStream;
    logic        ipTxReady;
    UART_PACKET  ipRxStream;
    logic [31:0] opRdData;
    logic        opRdValid;
    logic        opWrDone;
    logic        opError;
    logic        opBusy;

    int compared;
    int mismatched;

    register_access_master #(
        .BLOCK_WIDTH    (32),
        .LOCAL_ADDR     (LocalAddr),
        .TIMEOUT_CYCLES (100)
    ) dut (
        .ipClk        (ipClk),
        .ipReset      (ipReset),
        .ipCmdValid   (ipCmdValid),
        .opCmdReady   (opCmdReady),
        .ipCmdWrite   (ipCmdWrite),
        .ipCmdAddress (ipCmdAddress),
        .ipCmdData    (ipCmdData),
        .opTxStream   (opTxStream),
        .ipTxReady    (ipTxReady),
        .ipRxStream   (ipRxStream),
        .opRdData     (opRdData),
        .opRdValid    (opRdValid),
        .opWrDone     (opWrDone),
        .opError      (opError),
        .opBusy       (opBusy)
    );

    initial begin
        ipClk = 1'b0;
        forever #5 ipClk = ~ipClk;
    end

    function automatic UART_PACKET mkPkt(input logic [7:0] src, input logic [7:0] dst,
                                         input logic [7:0] len, input logic [7:0] data,
                                         input logic sop, input logic eop);
        UART_PACKET p;
        p.Source      = src;
        p.Destination = dst;
        p.Length      = len;
        p.Data        = data;
        p.SoP         = sop;
        p.EoP         = eop;
        p.Valid       = 1'b1;
        return p;
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge ipClk);
        #1;
    endtask

    task automatic issue(input logic wr, input logic [7:0] addr, input logic [31:0] data);
        ipCmdValid   = 1'b1;
        ipCmdWrite   = wr;
        ipCmdAddress = addr;
        ipCmdData    = data;
        step();
        ipCmdValid   = 1'b0;
    endtask

    task automatic rxByte(input logic [7:0] data, input logic sop, input logic eop);
        ipRxStream = mkPkt(8'h40, CMD_READ, 8'd5, data, sop, eop);
        step();
    endtask

    initial begin
        logic [7:0] wrBytes [5];
        int         hs;
        logic       rdy;

        compared     = 0;
        mismatched   = 0;
        ipReset      = 1'b0;
        ipCmdValid   = 1'b0;
        ipCmdWrite   = 1'b0;
        ipCmdAddress = 8'h00;
        ipCmdData    = 32'h0;
        ipTxReady    = 1'b1;
        ipRxStream   = '0;
        wrBytes      = '{8'h02, 8'hD4, 8'hC3, 8'hB2, 8'hA1};

        #23 ipReset = 1'b1;
        step();

        // Reset state
        check("rst_ready", 64'(opCmdReady), 64'd1);
        check("rst_busy", 64'(opBusy), 64'd0);
        check("rst_tx", 64'(opTxStream), 64'd0);
        check("rst_rddata", 64'(opRdData), 64'd0);
        check("rst_rdvalid", 64'(opRdValid), 64'd0);
        check("rst_wrdone", 64'(opWrDone), 64'd0);
        check("rst_error", 64'(opError), 64'd0);

        // Write, transmitter always ready
        issue(1'b1, 8'h02, 32'hA1B2C3D4);
        for (int i = 0; i < 5; i++) begin
            check($sformatf("wr_byte%0d", i), 64'(opTxStream),
                  64'(mkPkt(LocalAddr, 8'h01, 8'd5, wrBytes[i], i == 0, i == 4)));
            check($sformatf("wr_nodone%0d", i), 64'(opWrDone), 64'd0);
            step();
        end
        check("wr_done", 64'(opWrDone), 64'd1);
        check("wr_ready", 64'(opCmdReady), 64'd1);
        check("wr_txidle", 64'(opTxStream), 64'd0);
        step();
        check("wr_done_clr", 64'(opWrDone), 64'd0);

        // Write with ready pattern 1,0,0,1 repeating
        issue(1'b1, 8'h02, 32'hA1B2C3D4);
        hs = 0;
        for (int c = 0; c < 40 && hs < 5; c++) begin
            check($sformatf("wrbp_c%0d_b%0d", c, hs), 64'(opTxStream),
                  64'(mkPkt(LocalAddr, 8'h01, 8'd5, wrBytes[hs], hs == 0, hs == 4)));
            rdy       = (c % 4 == 0) || (c % 4 == 3);
            ipTxReady = rdy;
            step();
            if (rdy) hs++;
        end
        ipTxReady = 1'b1;
        check("wrbp_done", 64'(opWrDone), 64'd1);
        check("wrbp_ready", 64'(opCmdReady), 64'd1);

        // Good read
        issue(1'b0, 8'h05, 32'hDEADBEEF);
        check("rd_req", 64'(opTxStream), 64'(mkPkt(LocalAddr, 8'h00, 8'd1, 8'h05, 1'b1, 1'b1)));
        step();
        check("rd_wait_busy", 64'(opBusy), 64'd1);
        check("rd_wait_tx", 64'(opTxStream), 64'd0);
        rxByte(8'h05, 1'b1, 1'b0);
        rxByte(8'h78, 1'b0, 1'b0);
        rxByte(8'h56, 1'b0, 1'b0);
        rxByte(8'h34, 1'b0, 1'b0);
        check("rd_novalid", 64'(opRdValid), 64'd0);
        rxByte(8'h12, 1'b0, 1'b1);
        ipRxStream = '0;
        check("rd_valid", 64'(opRdValid), 64'd1);
        check("rd_data", 64'(opRdData), 64'h12345678);
        check("rd_ready", 64'(opCmdReady), 64'd1);
        step();
        check("rd_valid_clr", 64'(opRdValid), 64'd0);
        check("rd_data_hold", 64'(opRdData), 64'h12345678);

        // Read with wrong echoed address
        issue(1'b0, 8'h05, 32'h0);
        step();
        rxByte(8'h06, 1'b1, 1'b0);
        ipRxStream = '0;
        check("err_pulse", 64'(opError), 64'd1);
        check("err_rdvalid", 64'(opRdValid), 64'd0);
        check("err_data_kept", 64'(opRdData), 64'h12345678);
        check("err_ready", 64'(opCmdReady), 64'd1);
        step();
        check("err_clr", 64'(opError), 64'd0);
        check("err_idle", 64'(opBusy), 64'd0);

        // Read with no response
        issue(1'b0, 8'h09, 32'h0);
        step();
`ifdef TIMEOUT_EN
        repeat (99) step();
        check("to_early", 64'(opError), 64'd0);
        check("to_busy", 64'(opBusy), 64'd1);
        step();
        check("to_error", 64'(opError), 64'd1);
        check("to_ready", 64'(opCmdReady), 64'd1);
        step();
`else
        repeat (200) step();
        check("noto_busy", 64'(opBusy), 64'd1);
        check("noto_error", 64'(opError), 64'd0);
        ipReset = 1'b0;
        #2 ipReset = 1'b1;
        step();
`endif

        // Reset during the third byte of a write
        issue(1'b1, 8'h02, 32'hA1B2C3D4);
        step();
        step();
        check("rstmid_byte2", 64'(opTxStream),
              64'(mkPkt(LocalAddr, 8'h01, 8'd5, 8'hC3, 1'b0, 1'b0)));
        ipReset = 1'b0;
        #1;
        check("rstmid_tx", 64'(opTxStream), 64'd0);
        check("rstmid_ready", 64'(opCmdReady), 64'd1);
        check("rstmid_rddata", 64'(opRdData), 64'd0);
        #2 ipReset = 1'b1;
        step();
        issue(1'b0, 8'h33, 32'h0);
        check("rstmid_newpkt", 64'(opTxStream),
              64'(mkPkt(LocalAddr, 8'h00, 8'd1, 8'h33, 1'b1, 1'b1)));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/register_access_master.md
# register_access_master

Packet-level initiator for the UART register-access protocol: takes single read/write commands from local logic, serialises them as a UART_PACKET byte stream toward the UART packet transmitter, and for reads parses the returning response packet. It is the host-side counterpart of the on-chip register responder. It sits between a command source (test sequencer or peer-FPGA logic) and the UART_Packets block.

## Interface
- BLOCK_WIDTH, 32: register data width; fixed at 4 bytes.
- LOCAL_ADDR, 8'h00: value driven on the Source field of every request packet.
- TIMEOUT_CYCLES, 50_000_000: read-response timeout in ipClk cycles; only used with TIMEOUT_EN.

Ports:
- ipClk  in  1  single clock.
- ipReset  in  1  asynchronous, active-low reset.
- ipCmdValid  in  1  command request.
- opCmdReady  out  1  command accept; high only in IDLE.
- ipCmdWrite  in  1  1 = write, 0 = read.
- ipCmdAddress  in  8  register address.
- ipCmdData  in  32  write data; ignored for reads.
- opTxStream  out  UART_PACKET  request byte stream.
- ipTxReady  in  1  transmitter accepts the current byte.
- ipRxStream  in  UART_PACKET  incoming byte stream; no backpressure.
- opRdData  out  32  read result; holds until next read completes.
- opRdValid  out  1  one-cycle pulse, read data valid.
- opWrDone  out  1  one-cycle pulse, write fully handed to transmitter.
- opError  out  1  one-cycle pulse, malformed or timed-out response.
- opBusy  out  1  high in any state but IDLE.

## Operation
- States: IDLE, SEND, WAIT_RSP, RECV. Commands are captured into holding registers on ipCmdValid && opCmdReady.
- Write request:
  - Destination = CMD_WRITE (8'h01), Length = 5.
  - Data bytes: address, then data[7:0], [15:8], [23:16], [31:24].
- Read request:
  - Destination = CMD_READ (8'h00), Length = 1.
  - Data byte: address.
- Every request byte carries Source = LOCAL_ADDR. The first byte has SoP = 1 and the last has EoP = 1; a single-byte packet has both.
- SEND: Valid held with stable fields until ipTxReady is high. The byte index advances on Valid && ipTxReady. After the last byte, a write goes to IDLE with opWrDone and a read goes to WAIT_RSP.
- WAIT_RSP: an ipRxStream byte with Valid && SoP && Destination == CMD_READ && Length == 5 enters RECV as byte 0. Anything else is ignored.
- RECV:
  - Byte 0 must equal the pending address.
  - Bytes 1-4 assemble data LSB first.
  - EoP on byte 4 gives opRdValid and returns to IDLE.
  - Address mismatch, EoP before byte 4, or no EoP on byte 4 gives opError and returns to IDLE.
  - A new SoP mid-RECV restarts the parse at byte 0.
- Rx bytes in IDLE or SEND are discarded.

## Timing
- Reset values: opTxStream all zero (Valid = 0), opCmdReady = 1, opRdData = 0, opRdValid = 0, opWrDone = 0, opError = 0, opBusy = 0, state IDLE.
- Reset mid-packet drops Valid immediately. No EoP is sent.
- First request byte is valid the cycle after command accept.
- With ipTxReady tied high, a write takes 5 cycles in SEND and a read takes 1.
- opWrDone pulses the cycle after the final byte handshake. opCmdReady reasserts that same cycle.
- opRdValid pulses the cycle after the EoP byte is sampled. opRdData updates the same cycle.
- The next command can be accepted on the cycle opRdValid, opWrDone or opError is high.

## Configuration
- TIMEOUT_EN defined:
  - A counter clears on entering WAIT_RSP and counts in WAIT_RSP and RECV.
  - Reaching TIMEOUT_CYCLES − 1 pulses opError and returns to IDLE.
  - Counter width is $clog2(TIMEOUT_CYCLES).
- TIMEOUT_EN undefined: no counter; the block waits for a response indefinitely.

## Structure
- Structures package gains:
  - CMD_WRITE and CMD_READ constants;
  - REG_RSP_LENGTH = 5;
  - a REG_CMD struct {Write, Address[7:0], Data[31:0]}.
- UART_PACKET is reused unchanged.
- One sub-module, register_response_parser, owns the RECV byte checking and data assembly. The top module owns the FSM, the serialiser and the timeout.

## Test plan
- Write addr 8'h02, data 32'hA1B2C3D4, ipTxReady high: bytes are 02, D4, C3, B2, A1, all with Destination 01 and Length 5, SoP on the first byte and EoP on the last. opWrDone follows one cycle after the last byte.
- Same write with ipTxReady toggling 1,0,0,1,…: each byte is held stable while not ready. There are no duplicate or skipped bytes.
- Read addr 8'h05 followed by a response 05, 78, 56, 34, 12 with EoP on the last byte: opRdData = 32'h12345678 with a one-cycle opRdValid.
- Read addr 8'h05 with a response whose byte 0 is 8'h06: opError pulses, opRdData is unchanged, and the block returns to IDLE.
- With TIMEOUT_EN and TIMEOUT_CYCLES = 100, a read with no response: opError pulses exactly 100 cycles after entering WAIT_RSP. Without the macro, opBusy stays high.
- Assert ipReset during the third byte of a write: opTxStream.Valid = 0 immediately. After release, a new command is accepted and its packet starts with SoP.
